// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with presence and a 40-bit frame.
// Define DHT11_CRC_INJECT_EN to add crc_err_i, which inverts the transmitted checksum.
module dht11_responder #(
    parameter int CLK_PER_US   = 50,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 27,
    parameter int BIT1_HIGH_US = 70
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        dht11_io,
    input  logic [7:0] hum_int_i,
    input  logic [7:0] hum_dec_i,
    input  logic [7:0] temp_int_i,
    input  logic [7:0] temp_dec_i,
`ifdef DHT11_CRC_INJECT_EN
    input  logic       crc_err_i,
`endif
    output logic       busy_o,
    output logic       frame_done_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_DET = 4'd1,
        WAIT_REL  = 4'd2,
        RESP_WAIT = 4'd3,
        RESP_LOW  = 4'd4,
        RESP_HIGH = 4'd5,
        BIT_LOW   = 4'd6,
        BIT_HIGH  = 4'd7,
        EOF_LOW   = 4'd8
    } state_t;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int MAX_US = max2(max2(max2(START_MIN_US, RESP_WAIT_US), max2(RESP_LOW_US, RESP_HIGH_US)),
                                 max2(BIT_LOW_US, max2(BIT0_HIGH_US, BIT1_HIGH_US)));
    localparam int CW = $clog2(MAX_US * CLK_PER_US + 1);
    localparam logic [CW-1:0] T_START = CW'(START_MIN_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_WAIT  = CW'(RESP_WAIT_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_RLOW  = CW'(RESP_LOW_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_RHIGH = CW'(RESP_HIGH_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_BLOW  = CW'(BIT_LOW_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_BIT0  = CW'(BIT0_HIGH_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_BIT1  = CW'(BIT1_HIGH_US * CLK_PER_US - 1);

    state_t        state_q;
    logic [1:0]    sync_q;
    logic          line_prev_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    bit_q;
    logic [39:0]   shift_q;
    logic [39:0]   snap_d;
    logic          busy_q;
    logic          done_q;
    logic          crc_inv;
    logic [7:0]    sum;
    logic [CW-1:0] hi_end;

`ifdef DHT11_CRC_INJECT_EN
    assign crc_inv = crc_err_i;
`else
    assign crc_inv = 1'b0;
`endif

    assign sum    = 8'(hum_int_i + hum_dec_i + temp_int_i + temp_dec_i);
    assign snap_d = {hum_int_i, hum_dec_i, temp_int_i, temp_dec_i, sum ^ {8{crc_inv}}};
    assign hi_end = shift_q[39] ? T_BIT1 : T_BIT0;

    // Only low-driving states pull the line; everything else leaves it to the pull-up.
    assign dht11_io = (state_q == RESP_LOW || state_q == BIT_LOW || state_q == EOF_LOW) ? 1'b0 : 1'bz;

    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign state_o      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            line_prev_q <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], dht11_io};
            line_prev_q <= sync_q[1];
            done_q      <= 1'b0;
            cnt_q       <= cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (line_prev_q && !sync_q[1]) state_q <= START_DET;
                end
                START_DET: begin
                    if (sync_q[1]) state_q <= IDLE;
                    else if (cnt_q == T_START) begin
                        state_q <= WAIT_REL;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    cnt_q <= '0;
                    if (sync_q[1]) begin
                        state_q <= RESP_WAIT;
                        shift_q <= snap_d;
                        bit_q   <= '0;
                    end
                end
                RESP_WAIT: if (cnt_q == T_WAIT) begin
                    state_q <= RESP_LOW;
                    cnt_q   <= '0;
                end
                RESP_LOW: if (cnt_q == T_RLOW) begin
                    state_q <= RESP_HIGH;
                    cnt_q   <= '0;
                end
                RESP_HIGH: if (cnt_q == T_RHIGH) begin
                    state_q <= BIT_LOW;
                    cnt_q   <= '0;
                end
                BIT_LOW: if (cnt_q == T_BLOW) begin
                    state_q <= BIT_HIGH;
                    cnt_q   <= '0;
                end
                BIT_HIGH: if (cnt_q == hi_end) begin
                    cnt_q   <= '0;
                    shift_q <= {shift_q[38:0], 1'b0};
                    bit_q   <= bit_q + 6'd1;
                    state_q <= (bit_q == 6'd39) ? EOF_LOW : BIT_LOW;
                end
                EOF_LOW: if (cnt_q == T_BLOW) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: randomized host-side stimulus checked cycle by cycle against a protocol timeline model.
module tb_dht11_responder;
    localparam int CPU  = 2;
    localparam int SMIN = 100;

    typedef struct packed {
        logic       bus;
        logic       busy;
        logic       done;
        logic [3:0] st;
        logic       cb;
        logic       cs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_low = 1'b0;
    logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
`ifdef DHT11_CRC_INJECT_EN
    logic crc_err = 1'b0;
`endif
    logic       busy, done;
    logic [3:0] st;
    wire        dht11_io;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic cap_q[$];
    logic cap_en = 1'b0;
    int   runs[$];
    int   bit20_off;

    assign dht11_io = host_low ? 1'b0 : 1'bz;
    pullup (dht11_io);

    always #5 clk = ~clk;

    dht11_responder #(.CLK_PER_US(CPU), .START_MIN_US(SMIN)) dut (
        .clk(clk),
        .rst(rst),
        .dht11_io(dht11_io),
        .hum_int_i(hum_int),
        .hum_dec_i(hum_dec),
        .temp_int_i(temp_int),
        .temp_dec_i(temp_dec),
`ifdef DHT11_CRC_INJECT_EN
        .crc_err_i(crc_err),
`endif
        .busy_o(busy),
        .frame_done_o(done),
        .state_o(st)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Timeline of expected {bus, busy, done, state} per cycle, with don't-care masks.
    task automatic push(input logic bus, input logic [3:0] s, input int n, input logic bz,
                        input logic dn, input logic cb, input logic cs);
        exp_t e;
        e.bus = bus; e.busy = bz; e.done = dn; e.st = s; e.cb = cb; e.cs = cs;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cap_en) cap_q.push_back(dht11_io);
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("cycle", {57'd0, dht11_io, cur.cb & busy, done, cur.cs ? st : 4'd0},
                           {57'd0, cur.bus, cur.cb & cur.busy, cur.done, cur.cs ? cur.st : 4'd0});
        end
    end

    function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d, input logic inj);
        return {a, b, c, d, 8'(a + b + c + d) ^ {8{inj}}};
    endfunction

    task automatic drain();
        for (int i = 0; i < 30000 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic host_start(input int us);
        int n, smin;
        n = us * CPU;
        smin = SMIN * CPU;
        host_low = 1'b1;
        for (int i = 0; i < n; i++)
            push(1'b0, 4'd0, 1, i >= smin, 1'b0, i < smin || i >= smin + 3, 1'b0);
        repeat (n) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    task automatic short_release();
        push(1'b1, 4'd0, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b1, 4'd0, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Release follows the 2-flop synchronizer plus one register cycle before the response begins.
    task automatic release_frame(input logic [39:0] f);
        cap_q.delete();
        cap_en = 1'b1;
        push(1'b1, 4'd2, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        push(1'b1, 4'd3, 30 * CPU, 1'b1, 1'b0, 1'b1, 1'b1);
        push(1'b0, 4'd4, 80 * CPU, 1'b1, 1'b0, 1'b1, 1'b1);
        push(1'b1, 4'd5, 80 * CPU, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 39; i >= 0; i--) begin
            push(1'b0, 4'd6, 50 * CPU, 1'b1, 1'b0, 1'b1, 1'b1);
            if (i == 19) bit20_off = exp_q.size();
            push(1'b1, 4'd7, (f[i] ? 70 : 27) * CPU, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        push(1'b0, 4'd8, 50 * CPU, 1'b1, 1'b0, 1'b1, 1'b1);
        push(1'b1, 4'd0, 1, 1'b0, 1'b1, 1'b1, 1'b1);
        push(1'b1, 4'd0, 6, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    function automatic int run_at(input int i);
        return i < runs.size() ? runs[i] : -1;
    endfunction

    task automatic finish_frame(input string name, input logic [39:0] want);
        int len;
        logic [39:0] bits;
        drain();
        cap_en = 1'b0;
        runs.delete();
        len = 0;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (i > 0 && cap_q[i] != cap_q[i-1]) begin
                runs.push_back(len);
                len = 0;
            end
            len++;
        end
        runs.push_back(len);
        check({name, "_runs"}, 64'(runs.size()), 64'd85);
        bits = '0;
        for (int i = 0; i < 40; i++) bits = {bits[38:0], run_at(4 + 2 * i) > (27 + 70) * CPU / 2};
        check({name, "_frame"}, 64'(bits), 64'(want));
    endtask

    task automatic idle_reset(input int n);
        rst = 1'b1;
        push(1'b1, 4'd0, n, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        push(1'b1, 4'd0, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
    endtask

    task automatic set_bytes(input logic [7:0] a, b, c, d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
    endtask

    initial begin
        logic [39:0] f;
        logic [7:0] a, b, c, d;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        push(1'b1, 4'd0, 10, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        f = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        check("model_c3", 64'(f), 64'h3700190555);
        f = model_frame(8'hFF, 8'hFF, 8'hFF, 8'hFE, 1'b0);
        check("model_wrap", 64'(f), 64'hFFFFFFFEFB);
        f = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
        check("model_inj", 64'(f), 64'h37001905AA);
        idle_reset(3);
        host_start(60);
        short_release();
        drain();
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        host_start(120);
        release_frame(model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0));
        finish_frame("c3", 40'h3700190555);
        check("c3_wait", 64'(run_at(0)), 64'd63);
        check("c3_resp_low", 64'(run_at(1)), 64'd160);
        check("c3_resp_high", 64'(run_at(2)), 64'd160);
        check("c3_bit_low", 64'(run_at(3)), 64'd100);
        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFE);
        host_start(110);
        release_frame(model_frame(8'hFF, 8'hFF, 8'hFF, 8'hFE, 1'b0));
        finish_frame("c4", 40'hFFFFFFFEFB);
        check("c4_one_high", 64'(run_at(4)), 64'd140);
        check("c4_zero_high", 64'(run_at(66)), 64'd54);
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        host_start(115);
        release_frame(model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0));
        repeat (2400) @(posedge clk);
        #1 temp_int = 8'h20;
        finish_frame("c5", 40'h3700190555);
        temp_int = 8'h19;
        host_start(120);
        release_frame(model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0));
        repeat (bit20_off + 10) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        cap_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        push(1'b1, 4'd0, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        host_start(120);
        release_frame(model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0));
        finish_frame("c6", 40'h3700190555);
`ifdef DHT11_CRC_INJECT_EN
        crc_err = 1'b1;
        host_start(120);
        release_frame(model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b1));
        #1 crc_err = 1'b0;
        finish_frame("c7", 40'h37001905AA);
`endif
        for (int k = 0; k < 2; k++) begin
            host_start(int'($urandom_range(5, 90)));
            short_release();
            drain();
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            set_bytes(a, b, c, d);
            host_start(int'($urandom_range(105, 140)));
            release_frame(model_frame(a, b, c, d, 1'b0));
            finish_frame("rand", model_frame(a, b, c, d, 1'b0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
